ibex_mem_responder: RTL and testbench

IBEX_MEM_RESPONDER -- requirements
Module: ibex_mem_responder

---
 rtl/ibex_mem_responder.sv | 100 ++++++++++
 tb/tb_ibex_mem_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ibex_mem_responder: Ibex req/gnt/rvalid memory model, in-order responses  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ibex_mem_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] AddrBase       = 32'h0000_0000,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        stall_i,
  input  logic        rsp_stall_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IdxW = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  logic [31:0]     mem [MemWords];
  logic [32:0]     fifo_q [MaxOutstanding];   // {err, rdata}
  logic [PtrW-1:0] wptr;
  logic [PtrW-1:0] rptr;
  logic [CntW-1:0] count;

  logic [31:0]     offset;
  logic [31:0]     word_idx;
  logic [IdxW-1:0] mem_idx;
  logic            in_range;
  logic            accept;
  logic            pop;
  logic [32:0]     push_entry;
  logic [32:0]     head;

  assign offset   = addr_i - AddrBase;
  assign word_idx = offset >> 2;
  assign mem_idx  = word_idx[IdxW-1:0];
  assign in_range = (addr_i >= AddrBase) && (word_idx < MemWords);

  // Grant looks only at registered occupancy, never at a same-cycle pop.
  assign gnt_o  = req_i & ~stall_i & (32'(count) < MaxOutstanding);
  assign accept = req_i & gnt_o;
  assign pop    = (count != '0) & ~rsp_stall_i;

  assign push_entry = {~in_range, (in_range & ~we_i) ? mem[mem_idx] : 32'h0};
  assign head       = fifo_q[rptr];

  assign rvalid_o = pop;
  assign rdata_o  = pop ? head[31:0] : 32'h0;
  assign err_o    = pop & head[32];

  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_q[wptr] <= push_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept) begin
        wptr <= (wptr == LastPtr) ? '0 : wptr + PtrW'(1);
      end
      if (pop) begin
        rptr <= (rptr == LastPtr) ? '0 : rptr + PtrW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ibex_mem_responder.sv
`default_nettype none
// Scoreboard bench for ibex_mem_responder: expected responses queued at grant,
// compared in order as rvalid pulses appear.
module tb_ibex_mem_responder;

  localparam int unsigned MEM_WORDS = 16;
  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam int unsigned MAX_OUT   = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i, stall_i, rsp_stall_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;

  ibex_mem_responder #(
    .MemWords      (MEM_WORDS),
    .AddrBase      (BASE),
    .MaxOutstanding(MAX_OUT)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .we_i       (we_i),
    .be_i       (be_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .stall_i    (stall_i),
    .rsp_stall_i(rsp_stall_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int          tests  = 0;
  int          failed = 0;
  int          rv_cnt = 0;
  logic [32:0] exp_q[$];
  logic [31:0] model [MEM_WORDS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one granted request: update model, queue response.
  task automatic push_exp(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wd);
    logic        in_rng;
    int unsigned idx;
    in_rng = (addr >= BASE) && (((addr - BASE) >> 2) < MEM_WORDS);
    idx    = (addr - BASE) >> 2;
    if (!in_rng) begin
      exp_q.push_back({1'b1, 32'h0});
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
      exp_q.push_back({1'b0, 32'h0});
    end else begin
      exp_q.push_back({1'b0, model[idx]});
    end
  endtask

  // Leaves req_i high so consecutive calls form a back-to-back stream.
  task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, output int waits);
    req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wd;
    waits = 0;
    forever begin
      @(negedge clk_i);
      if (gnt_o) break;
      waits++;
      if (waits > 50) begin
        check("gnt_timeout", 32'd0, 32'd1);
        req_i = 1'b0;
        return;
      end
    end
    push_exp(we, be, addr, wd);
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    req_i = 1'b0;
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (rvalid_o) begin
        rv_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("rdata", rdata_o, e[31:0]);
          check("err", {31'd0, err_o}, {31'd0, e[32]});
        end
      end else begin
        check("idle_rdata", rdata_o, 32'h0);
        check("idle_err", {31'd0, err_o}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, g, base;
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = '0; wdata_i = '0;
    stall_i = 1'b0; rsp_stall_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Basic write/read, partial-byte merge, be=0 and ignored low address bits
    do_req(1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF, w);
    do_req(1'b0, 4'hF, BASE + 32'h10, 32'h0, w);
    do_req(1'b1, 4'hF, BASE + 32'h20, 32'h1122_3344, w);
    do_req(1'b1, 4'h1, BASE + 32'h20, 32'h0000_00AA, w);
    do_req(1'b0, 4'hF, BASE + 32'h20, 32'h0, w);
    idle(2);
    check("merge_model", model[8], 32'h1122_33AA);
    do_req(1'b1, 4'h0, BASE + 32'h20, 32'hFFFF_FFFF, w);
    do_req(1'b1, 4'h4, BASE + 32'h10, 32'h0077_0000, w);
    do_req(1'b0, 4'hF, BASE + 32'h13, 32'h0, w);
    do_req(1'b0, 4'hF, BASE + 32'h20, 32'h0, w);

    // Out-of-range above and below the window; aliased word 0 must survive
    do_req(1'b1, 4'hF, BASE, 32'hCAFE_F00D, w);
    do_req(1'b0, 4'hF, BASE + 4 * MEM_WORDS, 32'h0, w);
    do_req(1'b1, 4'hF, BASE + 4 * MEM_WORDS, 32'h5555_5555, w);
    do_req(1'b0, 4'hF, BASE - 32'h4, 32'h0, w);
    do_req(1'b0, 4'hF, BASE, 32'h0, w);
    idle(3);

    // stall_i blocks grant
    stall_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = BASE;
    @(negedge clk_i);
    check("stall_i_gnt", {31'd0, gnt_o}, 32'd0);
    req_i = 1'b0; stall_i = 1'b0;
    @(posedge clk_i); #1;

    // Response back-pressure: occupancy caps grants
    rsp_stall_i = 1'b1; req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = BASE + 32'h10;
    g = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (gnt_o) begin
        push_exp(1'b0, 4'hF, BASE + 32'h10, 32'h0);
        g++;
      end
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    check("full_gnt_low", {31'd0, gnt_o}, 32'd0);
    check("full_grants", g, MAX_OUT);
    req_i = 1'b0;
    base = rv_cnt;
    rsp_stall_i = 1'b0;
    idle(3);
    check("drain_count", rv_cnt - base, MAX_OUT);
    do_req(1'b0, 4'hF, BASE, 32'h0, w);
    check("resume_gnt", w, 0);
    idle(2);

    // Reset with responses outstanding discards them
    rsp_stall_i = 1'b1;
    do_req(1'b0, 4'hF, BASE, 32'h0, w);
    do_req(1'b0, 4'hF, BASE + 32'h10, 32'h0, w);
    idle(1);
    rst_ni = 1'b0;
    rsp_stall_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid_rvalid", {31'd0, rvalid_o}, 32'd0);
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    base = rv_cnt;
    idle(3);
    check("rst_discard", rv_cnt - base, 0);
    do_req(1'b0, 4'hF, BASE + 32'h10, 32'h0, w);
    check("rst_gnt", w, 0);
    idle(2);

    // Back-to-back stream
    for (int i = 0; i < 8; i++) do_req(1'b1, 4'hF, BASE + 4 * i, 32'hA500_0000 + i, w);
    idle(2);
    base = rv_cnt;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 4'hF, BASE + 4 * (7 - i), 32'h0, w);
      check("b2b_gnt", w, 0);
    end
    req_i = 1'b0;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    check("b2b_rvalid", rv_cnt - base, 8);

    idle(3);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
